// File: rtl/param_calculator_core.sv
// Unsigned multi-cycle calculator core: operands and opcode stepped in by button
// pulses, shift-add multiply, restoring divide, and result chaining into A.
module param_calculator_core #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             ButU,
  input  logic             ButD,
  input  logic             ButL,
  input  logic             ButR,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] R,
  output logic             Flag,
  output logic             Done,
  output logic             QI,
  output logic             QGet_A,
  output logic             QGet_B,
  output logic             QGet_Op,
  output logic             QAdd,
  output logic             QSub,
  output logic             QMul,
  output logic             QDiv,
  output logic             QErr,
  output logic             QDone
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] S_I      = 4'd0;
  localparam logic [3:0] S_GET_A  = 4'd1;
  localparam logic [3:0] S_GET_B  = 4'd2;
  localparam logic [3:0] S_GET_OP = 4'd3;
  localparam logic [3:0] S_ADD    = 4'd4;
  localparam logic [3:0] S_SUB    = 4'd5;
  localparam logic [3:0] S_MUL    = 4'd6;
  localparam logic [3:0] S_DIV    = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  logic [3:0]         state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [1:0]         op_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   c_reg, r_reg;
  logic               flag_reg;
  // Multiply: prod accumulates, mcand shifts left, shift_reg holds the multiplier.
  // Divide: shift_reg holds dividend bits shifting out / quotient bits shifting in.
  logic [2*WIDTH-1:0] prod_reg, mcand_reg;
  logic [WIDTH-1:0]   shift_reg, rem_reg;

  logic [WIDTH:0]     add_full;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic               last_iter;

  assign add_full  = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod_step = prod_reg + (shift_reg[0] ? mcand_reg : '0);
  assign rem_shift = {rem_reg, shift_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, b_reg};
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  always_comb begin
    rem_step = rem_diff[WIDTH-1:0];
    quo_step = {shift_reg[WIDTH-2:0], 1'b1};
    // Borrow out of the trial subtraction means restore the shifted remainder.
    if (rem_diff[WIDTH]) begin
      rem_step = rem_shift[WIDTH-1:0];
      quo_step = {shift_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_I:      if (ButU) state_next = S_GET_A;
      S_GET_A:  if (ButL) state_next = S_I; else if (ButU) state_next = S_GET_B;
      S_GET_B:  if (ButL) state_next = S_I; else if (ButU) state_next = S_GET_OP;
      S_GET_OP: begin
        if (ButL) state_next = S_I;
        else if (ButU) begin
          case (In[1:0])
            2'b00:   state_next = S_ADD;
            2'b01:   state_next = S_SUB;
            2'b10:   state_next = S_MUL;
            default: state_next = (b_reg == '0) ? S_ERR : S_DIV;
          endcase
        end
      end
      S_ADD, S_SUB: state_next = S_DONE;
      S_MUL, S_DIV: if (last_iter) state_next = S_DONE;
      S_ERR:    if (ButR) state_next = S_I;
      S_DONE:   if (ButR) state_next = S_I; else if (ButD) state_next = S_GET_B;
      default:  state_next = S_I;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_I;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      cnt_reg   <= '0;
      c_reg     <= '0;
      r_reg     <= '0;
      flag_reg  <= 1'b0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      shift_reg <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Clearing on every edge that lands in QI makes outputs read 0 on arrival.
      if (state_next == S_I) begin
        a_reg     <= '0;
        b_reg     <= '0;
        op_reg    <= '0;
        cnt_reg   <= '0;
        c_reg     <= '0;
        r_reg     <= '0;
        flag_reg  <= 1'b0;
        prod_reg  <= '0;
        mcand_reg <= '0;
        shift_reg <= '0;
        rem_reg   <= '0;
      end else begin
        case (state_reg)
          S_GET_A: if (ButU) a_reg <= In;
          S_GET_B: if (ButU) b_reg <= In;
          S_GET_OP: begin
            if (ButU) begin
              op_reg    <= In[1:0];
              cnt_reg   <= '0;
              prod_reg  <= '0;
              rem_reg   <= '0;
              mcand_reg <= {{WIDTH{1'b0}}, a_reg};
              shift_reg <= (In[1:0] == 2'b10) ? b_reg : a_reg;
              if (state_next == S_ERR) begin
                c_reg    <= '1;
                r_reg    <= '0;
                flag_reg <= 1'b1;
              end
            end
          end
          S_ADD, S_SUB: begin
            r_reg <= '0;
            if (op_reg[0]) begin
              c_reg    <= a_reg - b_reg;
              flag_reg <= (a_reg < b_reg);
            end else begin
              c_reg    <= add_full[WIDTH-1:0];
              flag_reg <= add_full[WIDTH];
            end
          end
          S_MUL, S_DIV: begin
            cnt_reg <= cnt_reg + CW'(1);
            if (op_reg == 2'b10) begin
              prod_reg  <= prod_step;
              mcand_reg <= mcand_reg << 1;
              shift_reg <= shift_reg >> 1;
              if (last_iter) begin
                c_reg    <= prod_step[WIDTH-1:0];
                r_reg    <= '0;
                flag_reg <= |prod_step[2*WIDTH-1:WIDTH];
              end
            end else begin
              shift_reg <= quo_step;
              rem_reg   <= rem_step;
              if (last_iter) begin
                c_reg    <= quo_step;
                r_reg    <= rem_step;
                flag_reg <= 1'b0;
              end
            end
          end
          S_DONE: if (ButD) a_reg <= c_reg;
          default: ;
        endcase
      end
    end
  end

  logic [9:0] state_onehot;

  // Any unused encoding reads back as QI, matching where the FSM sends it next.
  for (genvar gi = 0; gi < 10; gi++) begin : g_state_dec
    assign state_onehot[gi] = (state_reg == 4'(gi)) || ((gi == 0) && (state_reg > S_DONE));
  end

  assign {QDone, QErr, QDiv, QMul, QSub, QAdd, QGet_Op, QGet_B, QGet_A, QI} = state_onehot;

  assign C    = c_reg;
  assign R    = r_reg;
  assign Flag = flag_reg;
  assign Done = (state_reg == S_DONE);

endmodule
